// File: rtl/irrigation_scheduler_if.sv
// Bus between the zone request/level inputs and the valve drivers of irrigation_scheduler.
interface irrigation_scheduler_if;
  logic [1:0] G1;
  logic [1:0] G2;
  logic       lvl_ok;
  logic       err_clr;
  logic [1:0] R1;
  logic [1:0] R2;
  logic [1:0] E;
  logic [1:0] zone;
  logic       busy;

  modport master (output G1, G2, lvl_ok, err_clr, input R1, R2, E, zone, busy);
  modport slave  (input G1, G2, lvl_ok, err_clr, output R1, R2, E, zone, busy);
endinterface

// File: rtl/irrigation_scheduler.sv
// Round-robin time-slicing of one water supply across four valves, with a dead gap
// between slots and a full shut-off while the tank level is low.
module irrigation_scheduler #(
  parameter int unsigned DWELL = 16,
  parameter int unsigned GAP   = 2
) (
  input logic                  clk,
  input logic                  reset,
  irrigation_scheduler_if.slave bus
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned ZW    = 2;
  localparam int unsigned NZ    = 4;
  localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP, S_LOW} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [ZW-1:0]    last, last_n;
  logic [ZW-1:0]    zone_q, zone_n;
  logic [NZ-1:0]    valves, valves_n;
  logic             busy_q, busy_n;
  logic             e0, e0_n, e1, e1_n;
  logic [NZ-1:0]    req;
  logic [ZW-1:0]    grant;
  logic             grant_ok;

  assign req      = {bus.G2, bus.G1};
  assign bus.R1   = valves[1:0];
  assign bus.R2   = valves[3:2];
  assign bus.E    = {e1, e0};
  assign bus.zone = zone_q;
  assign bus.busy = busy_q;

  // First requesting zone after the last one granted.
  always_comb begin
    logic [ZW-1:0] z;
    grant    = '0;
    grant_ok = 1'b0;
    for (int i = 1; i <= int'(NZ); i++) begin
      z = ZW'(last + ZW'(i));
      if (!grant_ok && req[z]) begin
        grant    = z;
        grant_ok = 1'b1;
      end
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    last_n   = last;
    zone_n   = zone_q;
    valves_n = valves;
    busy_n   = busy_q;
    e0_n     = e0;
    e1_n     = e1 & ~bus.err_clr;

    // Low level overrides every state; an abort flag set beats a same-cycle clear.
    if (!bus.lvl_ok) begin
      state_n  = S_LOW;
      valves_n = '0;
      busy_n   = 1'b0;
      e0_n     = 1'b1;
      if (state == S_RUN) e1_n = 1'b1;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (grant_ok) begin
            state_n  = S_RUN;
            valves_n = NZ'(1) << grant;
            busy_n   = 1'b1;
            cnt_n    = DWELL_LD;
            zone_n   = grant;
            last_n   = grant;
          end
        end
        S_RUN: begin
          if (!req[zone_q] || cnt == '0) begin
            state_n  = S_GAP;
            valves_n = '0;
            busy_n   = 1'b0;
            cnt_n    = GAP_LD;
          end else begin
            cnt_n = cnt - CNT_W'(1);
          end
        end
        S_GAP: begin
          if (cnt == '0) state_n = S_IDLE;
          else           cnt_n   = cnt - CNT_W'(1);
        end
        S_LOW: begin
          state_n = S_GAP;
          e0_n    = 1'b0;
          cnt_n   = GAP_LD;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      last   <= ZW'(3);
      zone_q <= '0;
      valves <= '0;
      busy_q <= 1'b0;
      e0     <= 1'b0;
      e1     <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      last   <= last_n;
      zone_q <= zone_n;
      valves <= valves_n;
      busy_q <= busy_n;
      e0     <= e0_n;
      e1     <= e1_n;
    end
  end

endmodule
